s27_bist_ctrl: RTL and testbench

//  Self-test wrapper stage for the s27 core. It drives the core's four primary inputs
//  (G3..G0) with LFSR pseudo-random patterns and compacts the core output G17 in a

---
 rtl/s27_bist_pkg.sv | 17 +
 rtl/bist_sisr.sv | 32 +++
 rtl/s27_bist_ctrl.sv | 122 ++++++++++++
 tb/tb_s27_bist_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s27_bist_pkg.sv
// Shared types and default constants for the s27 self-test wrapper.
// The SISR sub-module and the controller top both import this package.
package s27_bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    RUN,
    DONE
  } state_t;

  localparam logic [3:0] DEF_INIT_VEC  = 4'b1100;
  localparam logic [3:0] DEF_LFSR_SEED = 4'b0001;
  localparam logic [3:0] DEF_LFSR_TAPS = 4'b1100;
  localparam logic [7:0] DEF_SISR_TAPS = 8'hB8;

endpackage

// File: rtl/bist_sisr.sv
// Serial-input signature register compacting the core response, one bit per enabled clock.
// clr has priority over en so that a restart always begins from a zero signature.
module bist_sisr
  import s27_bist_pkg::*;
#(
  parameter int                SIG_W     = 8,
  parameter logic [SIG_W-1:0]  SISR_TAPS = DEF_SISR_TAPS
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_shift;

  always_comb begin
    sig_shift = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? SISR_TAPS : '0);
    sig_shift = sig_shift ^ {{(SIG_W-1){1'b0}}, din};
  end

  always_ff @(posedge CK) begin
    if (RST || clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= sig_shift;
    end
  end

endmodule

// File: rtl/s27_bist_ctrl.sv
// BIST controller for the s27 core: LFSR pattern source, INIT/RUN sequencing and
// signature comparison. Every output is decoded from registered state only.
module s27_bist_ctrl
  import s27_bist_pkg::*;
#(
  parameter int               PAT_W        = 4,
  parameter logic [PAT_W-1:0] LFSR_SEED    = DEF_LFSR_SEED,
  parameter logic [PAT_W-1:0] LFSR_TAPS    = DEF_LFSR_TAPS,
  parameter logic [PAT_W-1:0] INIT_VEC     = DEF_INIT_VEC,
  parameter int               INIT_CYCLES  = 3,
  parameter int               NUM_PATTERNS = 15,
  parameter int               SIG_W        = 8,
  parameter logic [SIG_W-1:0] SISR_TAPS    = DEF_SISR_TAPS
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             start,
  input  logic [SIG_W-1:0] golden,
  input  logic             cut_resp,
  output logic [PAT_W-1:0] pat,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] sig
);

  localparam int MAX_CNT = (INIT_CYCLES > NUM_PATTERNS) ? INIT_CYCLES : NUM_PATTERNS;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(NUM_PATTERNS - 1);

  generate
    if (LFSR_SEED == '0) begin : g_bad_seed
      $error("s27_bist_ctrl: LFSR_SEED must be non-zero");
    end
    if (INIT_CYCLES < 2) begin : g_bad_init
      $error("s27_bist_ctrl: INIT_CYCLES must be at least 2");
    end
    if (NUM_PATTERNS < 1) begin : g_bad_num
      $error("s27_bist_ctrl: NUM_PATTERNS must be at least 1");
    end
  endgenerate

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [PAT_W-1:0] lfsr, lfsr_n;
  logic [SIG_W-1:0] golden_q, golden_n;
  logic             sisr_clr, sisr_en;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    lfsr_n   = lfsr;
    golden_n = golden_q;
    sisr_clr = 1'b0;
    sisr_en  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n  = INIT;
          cnt_n    = '0;
          lfsr_n   = LFSR_SEED;
          sisr_clr = 1'b1;
        end
      end
      INIT: begin
        if (cnt == INIT_LAST) begin
          state_n = RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RUN: begin
        sisr_en = 1'b1;
        lfsr_n  = {lfsr[PAT_W-2:0], ^(lfsr & LFSR_TAPS)};
        // golden is latched on the final capture edge so pass needs no input path
        if (cnt == RUN_LAST) begin
          state_n  = DONE;
          golden_n = golden;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      lfsr     <= LFSR_SEED;
      golden_q <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      lfsr     <= lfsr_n;
      golden_q <= golden_n;
    end
  end

  bist_sisr #(
    .SIG_W     (SIG_W),
    .SISR_TAPS (SISR_TAPS)
  ) u_sisr (
    .CK  (CK),
    .RST (RST),
    .clr (sisr_clr),
    .en  (sisr_en),
    .din (cut_resp),
    .sig (sig)
  );

  always_comb begin
    pat  = (state == RUN) ? lfsr : INIT_VEC;
    busy = (state == INIT) || (state == RUN);
    done = (state == DONE);
    pass = (state == DONE) && (sig == golden_q);
  end

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// Directed self-checking bench for s27_bist_ctrl, including a gate-level s27 model
// that can be switched in as the response source.
module tb_s27_bist_ctrl;

  logic       CK = 1'b0;
  logic       RST = 1'b0;
  logic       start = 1'b0;
  logic [7:0] golden = 8'h00;
  logic       cut_resp;
  logic [3:0] pat;
  logic       busy, done, pass;
  logic [7:0] sig;

  logic tb_resp  = 1'b0;
  logic use_core = 1'b0;
  logic stuck    = 1'b0;

  int checks   = 0;
  int failures = 0;

  // s27 netlist model driven by the controller patterns
  logic g5, g6, g7;
  logic g0, g1, g2, g3;
  logic g8, g9, g10, g11, g12, g13, g14, g15, g16, g17;
  assign {g3, g2, g1, g0} = pat;
  assign g14 = ~g0;
  assign g8  = g14 & g6;
  assign g12 = ~(g1 | g7);
  assign g15 = g12 | g8;
  assign g16 = g3 | g8;
  assign g9  = ~(g16 & g15);
  assign g11 = ~(g5 | g9);
  assign g10 = ~(g14 | g11);
  assign g13 = ~(g2 | g12);
  assign g17 = ~g11;
  always @(posedge CK) begin
    g5 <= g10;
    g6 <= g11;
    g7 <= g13;
  end

  assign cut_resp = use_core ? (stuck ? 1'b0 : g17) : tb_resp;

  s27_bist_ctrl dut (
    .CK       (CK),
    .RST      (RST),
    .start    (start),
    .golden   (golden),
    .cut_resp (cut_resp),
    .pat      (pat),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .sig      (sig)
  );

  always #5 CK = ~CK;

  logic [3:0] exp_pat [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                               4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
  // signature after k captures, single 1 on the first RUN cycle
  logic [7:0] comp_sig [16] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                8'h80, 8'hB8, 8'hC8, 8'h28, 8'h50, 8'hA0, 8'hF8, 8'h48};
  // signature after k captures with the fault-free s27 as response source
  logic [7:0] core_sig [16] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0E, 8'h1D, 8'h3B, 8'h76,
                                8'hEC, 8'h61, 8'hC3, 8'h3F, 8'h7F, 8'hFF, 8'h46, 8'h8C};

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    start = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    checks++; if (pat !== 4'hC) begin failures++; $display("FAIL reset_pat got=%h exp=c", pat); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (pass !== 1'b0) begin failures++; $display("FAIL reset_pass got=%b exp=0", pass); end
    checks++; if (sig !== 8'h00) begin failures++; $display("FAIL reset_sig got=%h exp=00", sig); end
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || pat !== 4'hC || sig !== 8'h00) begin
        failures++;
        $display("FAIL idle_hold cyc=%0d got busy=%b done=%b pat=%h sig=%h exp 0 0 c 00",
                 k, busy, done, pat, sig);
      end
    end
  endtask

  task automatic test_sequencing();
    tb_resp = 1'b0;
    golden = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL seq_busy_rise got=%b exp=1", busy); end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      checks++;
      if (pat !== 4'hC || busy !== 1'b1) begin
        failures++;
        $display("FAIL seq_init cyc=%0d got pat=%h busy=%b exp c 1", k, pat, busy);
      end
    end
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if (pat !== exp_pat[i] || busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL seq_run cyc=%0d got pat=%h busy=%b done=%b exp %h 1 0",
                 i, pat, busy, done, exp_pat[i]);
      end
    end
    tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL seq_done got=%b exp=1", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL seq_busy_fall got=%b exp=0", busy); end
    checks++; if (sig !== 8'h00) begin failures++; $display("FAIL seq_sig got=%h exp=00", sig); end
    checks++; if (pass !== 1'b1) begin failures++; $display("FAIL seq_pass got=%b exp=1", pass); end
    checks++; if (pat !== 4'hC) begin failures++; $display("FAIL seq_pat_done got=%h exp=c", pat); end
    tick();
    tick();
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL seq_done_hold got done=%b pass=%b busy=%b exp 1 1 0", done, pass, busy);
    end
  endtask

  task automatic test_compaction();
    golden = 8'h48;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if (sig !== comp_sig[i]) begin
        failures++;
        $display("FAIL comp_sig cap=%0d got=%h exp=%h", i, sig, comp_sig[i]);
      end
      tb_resp = (i == 0);
    end
    tick();
    tb_resp = 1'b0;
    checks++; if (sig !== 8'h48) begin failures++; $display("FAIL comp_final got=%h exp=48", sig); end
    checks++; if (pass !== 1'b1) begin failures++; $display("FAIL comp_pass got=%b exp=1", pass); end

    golden = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || pass !== 1'b0 || sig !== 8'h00 || busy !== 1'b1) begin
      failures++;
      $display("FAIL comp_rerun_clear got done=%b pass=%b sig=%h busy=%b exp 0 0 00 1",
               done, pass, sig, busy);
    end
    tick();
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      tb_resp = (i == 0);
    end
    tick();
    tb_resp = 1'b0;
    checks++; if (sig !== 8'h48) begin failures++; $display("FAIL comp_final2 got=%h exp=48", sig); end
    checks++; if (pass !== 1'b0) begin failures++; $display("FAIL comp_nopass got=%b exp=0", pass); end
  endtask

  task automatic test_ignore_rearm();
    golden = 8'h48;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if (pat !== exp_pat[i] || done !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL ign_run cyc=%0d got pat=%h done=%b busy=%b exp %h 0 1",
                 i, pat, done, busy, exp_pat[i]);
      end
      tb_resp = (i == 0);
      start = (i == 5);
    end
    tick();
    tb_resp = 1'b0;
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || sig !== 8'h48 || pass !== 1'b1) begin
      failures++;
      $display("FAIL ign_done got done=%b sig=%h pass=%b exp 1 48 1", done, sig, pass);
    end

    // start held high through INIT and RUN must not disturb the run
    start = 1'b1;
    tick();
    checks++;
    if (done !== 1'b0 || pass !== 1'b0 || sig !== 8'h00 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rearm_clear got done=%b pass=%b sig=%h busy=%b exp 0 0 00 1",
               done, pass, sig, busy);
    end
    tick();
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if (pat !== exp_pat[i] || done !== 1'b0) begin
        failures++;
        $display("FAIL rearm_run cyc=%0d got pat=%h done=%b exp %h 0", i, pat, done, exp_pat[i]);
      end
      if (i == 14) start = 1'b0;
    end
    tick();
    checks++;
    if (done !== 1'b1 || sig !== 8'h00 || pass !== 1'b0) begin
      failures++;
      $display("FAIL rearm_done got done=%b sig=%h pass=%b exp 1 00 0", done, sig, pass);
    end
  endtask

  task automatic test_abort();
    golden = 8'h48;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 7; i++) begin
      tick();
      tb_resp = (i == 0);
      if (i == 6) RST = 1'b1;
    end
    tick();
    RST = 1'b0;
    tb_resp = 1'b0;
    checks++;
    if (pat !== 4'hC || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || sig !== 8'h00) begin
      failures++;
      $display("FAIL abort_reset got pat=%h busy=%b done=%b pass=%b sig=%h exp c 0 0 0 00",
               pat, busy, done, pass, sig);
    end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_idle got=%b exp=0", busy); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if (pat !== exp_pat[i] || done !== 1'b0) begin
        failures++;
        $display("FAIL abort_rerun cyc=%0d got pat=%h done=%b exp %h 0", i, pat, done, exp_pat[i]);
      end
      tb_resp = (i == 0);
    end
    tick();
    tb_resp = 1'b0;
    checks++;
    if (done !== 1'b1 || sig !== 8'h48 || pass !== 1'b1) begin
      failures++;
      $display("FAIL abort_final got done=%b sig=%h pass=%b exp 1 48 1", done, sig, pass);
    end
  endtask

  task automatic test_core(input logic stuck_fault);
    use_core = 1'b1;
    stuck = stuck_fault;
    golden = 8'h8C;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      if (!stuck_fault) begin
        checks++;
        if (sig !== core_sig[i]) begin
          failures++;
          $display("FAIL core_sig cap=%0d got=%h exp=%h", i, sig, core_sig[i]);
        end
      end
    end
    tick();
    if (!stuck_fault) begin
      checks++;
      if (sig !== 8'h8C || pass !== 1'b1) begin
        failures++;
        $display("FAIL core_good got sig=%h pass=%b exp 8c 1", sig, pass);
      end
    end else begin
      checks++;
      if (sig !== 8'h00 || pass !== 1'b0) begin
        failures++;
        $display("FAIL core_sa0 got sig=%h pass=%b exp 00 0", sig, pass);
      end
    end
    use_core = 1'b0;
    stuck = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequencing();
    test_compaction();
    test_ignore_rearm();
    test_abort();
    test_core(1'b0);
    test_core(1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
